// File: rtl/freq_display_scan.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with a stability
// filter on the incoming BCD bus, leading-zero blanking and a non-BCD error flag.
module freq_display_scan #(
  parameter int unsigned DIV      = 12500,
  parameter int unsigned STABLE   = 4,
  parameter bit          BLANK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [3:0] d7,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       err,
  output logic       frame
);

  localparam int unsigned   PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [3:0]    SMAX = 4'(STABLE);

  logic [31:0]   bus;
  logic [31:0]   smp;
  logic [31:0]   disp;
  logic [3:0]    scnt;
  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic          tick;
  logic [7:0]    blank;
  logic [3:0]    v;
  logic [6:0]    seg_next;
  logic          bad;

  assign bus  = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign tick = (pcnt == PMAX);

  // Bus is adopted only after it has matched the previous sample STABLE times in a row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp  <= '0;
      scnt <= '0;
      disp <= '0;
    end else begin
      smp <= bus;
      if (bus != smp) begin
        scnt <= '0;
      end else if (scnt != SMAX) begin
        scnt <= scnt + 4'd1;
        if (scnt == SMAX - 4'd1) disp <= smp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt  <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      pcnt  <= tick ? '0 : pcnt + 1'b1;
      frame <= tick && (idx == 3'd7);
      if (tick) idx <= idx + 3'd1;
    end
  end

  always_comb begin
    blank = '0;
    bad   = 1'b0;
    for (int unsigned i = 1; i < 8; i++) begin
      blank[i] = BLANK_EN && ((disp >> (4 * i)) == 32'd0);
    end
    for (int unsigned i = 0; i < 8; i++) begin
      if (disp[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    v = 4'(disp >> {idx, 2'b00});
    if (blank[idx]) begin
      seg_next = 7'h7F;
    end else begin
      case (v)
        4'd0:    seg_next = 7'h40;
        4'd1:    seg_next = 7'h79;
        4'd2:    seg_next = 7'h24;
        4'd3:    seg_next = 7'h30;
        4'd4:    seg_next = 7'h19;
        4'd5:    seg_next = 7'h12;
        4'd6:    seg_next = 7'h02;
        4'd7:    seg_next = 7'h78;
        4'd8:    seg_next = 7'h00;
        4'd9:    seg_next = 7'h10;
        default: seg_next = 7'h3F;
      endcase
    end
  end

  // an and seg share one edge so a digit never shows its neighbour's pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= '1;
      err <= 1'b0;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= seg_next;
      err <= bad;
    end
  end

endmodule

// File: tb/tb_freq_display_scan.sv
// Directed plus random bench for freq_display_scan against a cycle-count based
// reference model of the scan position and bus adoption.
module tb_freq_display_scan;

  localparam int DIV    = 4;
  localparam int STABLE = 4;

  logic        clk;
  logic        rst;
  logic [31:0] bus;
  logic [7:0]  an, an_nb;
  logic [6:0]  seg, seg_nb;
  logic        err, err_nb;
  logic        frame, frame_nb;

  int          checks;
  int          errors;

  // reference model state
  int          cyc;
  int          run;
  logic [31:0] last_seen;
  logic [31:0] exp_disp;

  localparam logic [6:0] SEGS [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  freq_display_scan #(.DIV(DIV), .STABLE(STABLE), .BLANK_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .d0(bus[3:0]), .d1(bus[7:4]), .d2(bus[11:8]), .d3(bus[15:12]),
    .d4(bus[19:16]), .d5(bus[23:20]), .d6(bus[27:24]), .d7(bus[31:28]),
    .an(an), .seg(seg), .err(err), .frame(frame)
  );

  freq_display_scan #(.DIV(DIV), .STABLE(STABLE), .BLANK_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst),
    .d0(bus[3:0]), .d1(bus[7:4]), .d2(bus[11:8]), .d3(bus[15:12]),
    .d4(bus[19:16]), .d5(bus[23:20]), .d6(bus[27:24]), .d7(bus[31:28]),
    .an(an_nb), .seg(seg_nb), .err(err_nb), .frame(frame_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] enc(logic [31:0] val, int dg, bit ben);
    logic [31:0] upper;
    int          dv;
    upper = val >> (4 * dg);
    dv    = int'(upper & 32'hF);
    if (ben && dg > 0 && upper == 32'd0) return 7'h7F;
    if (dv > 9) return 7'h3F;
    return SEGS[dv];
  endfunction

  function automatic bit has_bad(logic [31:0] val);
    for (int i = 0; i < 8; i++) begin
      if (((val >> (4 * i)) & 32'hF) > 32'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    run       = 0;
    exp_disp  = '0;
    last_seen = ~bus;
  endtask

  // Each step: one clock edge, model prediction from pre-edge state, check at edge+1
  task automatic step(input int n);
    int          dg;
    logic [7:0]  e_an;
    logic [6:0]  e_seg, e_seg_nb;
    logic        e_err, e_frame;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      dg       = ((cyc - 1) / DIV) % 8;
      e_an     = ~(8'd1 << dg);
      e_seg    = enc(exp_disp, dg, 1'b1);
      e_seg_nb = enc(exp_disp, dg, 1'b0);
      e_err    = has_bad(exp_disp);
      e_frame  = (cyc % (8 * DIV)) == 0;
      if (bus == last_seen) run++;
      else begin
        run       = 1;
        last_seen = bus;
      end
      if (run == STABLE + 1) exp_disp = bus;
      #1;
      chk("an", 32'(an), 32'(e_an));
      chk("an_nb", 32'(an_nb), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("seg_nb", 32'(seg_nb), 32'(e_seg_nb));
      chk("err", 32'(err), 32'(e_err));
      chk("frame", 32'(frame), 32'(e_frame));
      chk("disp", dut.disp, exp_disp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus    = '0;
    model_reset();

    // reset state
    #12;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    rst = 1'b1;

    // zero bus: two full frames of scanning
    step(2 * 8 * DIV + 3);

    // value display with leading zeros, blanked and unblanked
    bus = 32'h0012_3456;
    step(8 * DIV + STABLE + 8);

    // stability filter: short glitch rejected, then a held value adopted
    bus = 32'h1234_5678;
    step(8);
    bus = 32'h8765_4321;
    step(3);
    bus = 32'h1234_5678;
    step(6);
    bus = 32'h8765_4321;
    step(6);
    step(8 * DIV);

    // invalid digit, then recovery to a valid bus
    bus = 32'h0000_A000;
    step(8 * DIV + STABLE + 4);
    bus = 32'h0000_0000;
    step(STABLE + 4);

    // all-nines across the frame wrap
    bus = 32'h9999_9999;
    step(2 * 8 * DIV);

    // reset mid-frame while digit 5 is selected
    while (((cyc - 1) / DIV) % 8 != 5) step(1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'hFF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_frame", 32'(frame), 32'h0);
    chk("mid_rst_disp", dut.disp, 32'h0);
    @(posedge clk);
    #1;
    chk("held_rst_an", 32'(an), 32'hFF);
    chk("held_rst_seg", 32'(seg), 32'h7F);
    #3;
    rst = 1'b1;
    model_reset();
    step(8 * DIV + 2);

    // random buses and hold times, biased toward leading zeros and some non-BCD
    for (int k = 0; k < 40; k++) begin
      bus = $urandom >> (4 * $urandom_range(0, 7));
      step($urandom_range(1, 2 * STABLE + 4));
    end
    step(8 * DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
